// File: rtl/mips_mult_pkg.sv
// Shared types for the HI/LO multiply control stage: default width, FSM encoding, HI/LO selects.
package mips_mult_pkg;

  localparam int MULT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } mult_state_t;

  localparam logic SEL_LO = 1'b0;
  localparam logic SEL_HI = 1'b1;

endpackage

// File: rtl/mult_timeout_cnt.sv
// Counts WAIT cycles; o_expired flags the last permitted cycle (count == TIMEOUT-1) while enabled.
// Counter is registered, o_expired is combinational; no backpressure.
module mult_timeout_cnt #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_expired = i_en && (r_count == LAST);

endmodule

// File: rtl/hilo_mult_ctrl.sv
// Launches the sequential multiplier, captures produto into HI/LO, serves MF/MT; 1-cycle MF latency.
// Any request that cannot be taken this cycle (busy, or losing IDLE arbitration) raises stall.
module hilo_mult_ctrl
  import mips_mult_pkg::*;
#(
  parameter int W       = MULT_W,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mult_req,
  input  logic [W-1:0]   op_a,
  input  logic [W-1:0]   op_b,
  input  logic           mt_req,
  input  logic           mt_sel,
  input  logic [W-1:0]   mt_data,
  input  logic           mf_req,
  input  logic           mf_sel,
  output logic           St,
  output logic [W-1:0]   mndo,
  output logic [W-1:0]   mdor,
  input  logic           done1,
  input  logic [2*W-1:0] produto,
  output logic           busy,
  output logic           stall,
  output logic [W-1:0]   mf_data,
  output logic           mf_valid,
  output logic [W-1:0]   hi,
  output logic [W-1:0]   lo,
  output logic           err
);

  mult_state_t r_state;
  mult_state_t w_state_nxt;

  logic [W-1:0] r_mndo;
  logic [W-1:0] r_mdor;
  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;
  logic [W-1:0] r_mf_data;
  logic         r_mf_valid;
  logic         r_err;

  logic w_idle;
  logic w_cnt_clr;
  logic w_cnt_en;
  logic w_expired;
  logic w_capture;

  mult_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_cnt_clr),
    .i_en      (w_cnt_en),
    .o_expired (w_expired)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idle      = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_en    = 1'b0;
    w_capture   = 1'b0;
    St          = 1'b0;
    busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_idle = 1'b1;
        busy   = 1'b0;
        if (mult_req) w_state_nxt = ST_START;
      end
      ST_START: begin
        St          = 1'b1;
        w_cnt_clr   = 1'b1;
        w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        w_capture = done1;
        w_cnt_en  = !done1;
        if (done1 || w_expired) w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // In IDLE only the highest-priority request is taken; the rest wait.
    stall = (busy && (mult_req || mt_req || mf_req)) ||
            (w_idle && ((mult_req && (mt_req || mf_req)) || (mt_req && mf_req)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_mndo     <= '0;
      r_mdor     <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_mf_data  <= '0;
      r_mf_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mf_valid <= 1'b0;
      if (w_idle) begin
        if (mult_req) begin
          r_mndo <= op_a;
          r_mdor <= op_b;
          r_err  <= 1'b0;
        end else if (mt_req) begin
          if (mt_sel == SEL_HI) r_hi <= mt_data;
          else                  r_lo <= mt_data;
        end else if (mf_req) begin
          r_mf_data  <= (mf_sel == SEL_HI) ? r_hi : r_lo;
          r_mf_valid <= 1'b1;
        end
      end
      if (w_capture) begin
        r_hi <= produto[2*W-1:W];
        r_lo <= produto[W-1:0];
      end else if (w_expired) begin
        r_err <= 1'b1;
      end
    end
  end

  assign mndo     = r_mndo;
  assign mdor     = r_mdor;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign mf_data  = r_mf_data;
  assign mf_valid = r_mf_valid;
  assign err      = r_err;

endmodule
